// File: rtl/command_arbiter.sv
// Per-frame command scheduler: confirms camera gestures/keys over several frames,
// arbitrates button > key > gesture, issues one handshaked command, then cools down.
module command_arbiter #(
  parameter int CONFIRM_FRAMES  = 3,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       frame_tick_in,
  input  logic       gest_valid_in,
  input  logic [1:0] gest_dir_in,
  input  logic       key_valid_in,
  input  logic [1:0] key_in,
  input  logic [3:0] btn_rot_in,
  input  logic       btn_decide_in,
  input  logic       cmd_ready_in,
  output logic       cmd_valid_out,
  output logic [1:0] cmd_out,
  output logic [1:0] cmd_src_out,
  output logic       decide_out,
  output logic [1:0] state_out
);

  localparam int            CW            = $clog2(CONFIRM_FRAMES + 1);
  localparam logic [CW-1:0] CONFIRM_MAX   = CW'(CONFIRM_FRAMES);
  localparam logic [7:0]    COOLDOWN_LOAD = 8'(COOLDOWN_FRAMES);
  localparam int            NSRC          = 2;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_BTN  = 2'b01;
  localparam logic [1:0] SRC_GEST = 2'b10;
  localparam logic [1:0] SRC_KEY  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    PEND     = 2'b01,
    COOLDOWN = 2'b10
  } state_t;

  state_t     state_reg, state_next;
  logic       valid_reg, valid_next;
  logic [1:0] cmd_reg, cmd_next;
  logic [1:0] src_reg, src_next;
  logic [7:0] cool_reg, cool_next;

  logic       handshake;
  logic       cam_discard;
  logic       cnt_clear;

  assign handshake   = valid_reg & cmd_ready_in;
  assign cam_discard = (state_reg == COOLDOWN);
  assign cnt_clear   = cam_discard | handshake;

  // History registers reset high so a button held through reset never fires.
  logic [3:0] btn_q_reg;
  logic       decide_q_reg;
  logic       decide_reg;
  logic [3:0] btn_rise;
  logic       any_rise;
  logic [1:0] btn_code;

  assign btn_rise = btn_rot_in & ~btn_q_reg;
  assign any_rise = |btn_rise;

  always_comb begin
    btn_code = 2'b11;
    if (btn_rise[3])      btn_code = 2'b00;
    else if (btn_rise[2]) btn_code = 2'b01;
    else if (btn_rise[1]) btn_code = 2'b10;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      btn_q_reg    <= 4'hF;
      decide_q_reg <= 1'b1;
      decide_reg   <= 1'b0;
    end else begin
      btn_q_reg    <= btn_rot_in;
      decide_q_reg <= btn_decide_in;
      decide_reg   <= btn_decide_in & ~decide_q_reg;
    end
  end

  // Camera sources: index 0 is gesture, index 1 is key.
  logic [NSRC-1:0]   cam_valid;
  logic [2*NSRC-1:0] cam_code;
  logic [NSRC-1:0]   conf_hit;
  logic [2*NSRC-1:0] cand_upd_flat;

  assign cam_valid = {key_valid_in, gest_valid_in};
  assign cam_code  = {key_in, gest_dir_in};

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_cam
    logic [1:0]    latch_reg, latch_next;
    logic          seen_reg, seen_next;
    logic [1:0]    cand_reg, cand_next, cand_upd;
    logic [CW-1:0] cnt_reg, cnt_next, cnt_upd;
    logic          seen_eff;
    logic [1:0]    code_eff;

    // A pulse coincident with the tick still belongs to the frame now ending.
    assign seen_eff = seen_reg | cam_valid[gi];
    assign code_eff = cam_valid[gi] ? cam_code[gi*2 +: 2] : latch_reg;

    always_comb begin
      cand_upd = cand_reg;
      cnt_upd  = '0;
      if (seen_eff && (code_eff == cand_reg)) begin
        cnt_upd = (cnt_reg == CONFIRM_MAX) ? cnt_reg : cnt_reg + 1'b1;
      end else if (seen_eff) begin
        cand_upd = code_eff;
        cnt_upd  = CW'(1);
      end
    end

    always_comb begin
      latch_next = latch_reg;
      seen_next  = seen_reg;
      cand_next  = cand_reg;
      cnt_next   = cnt_reg;
      if (cam_valid[gi]) begin
        latch_next = cam_code[gi*2 +: 2];
        seen_next  = 1'b1;
      end
      if (frame_tick_in) begin
        seen_next = 1'b0;
        cand_next = cand_upd;
        cnt_next  = cnt_upd;
      end
      if (cam_discard) begin
        latch_next = latch_reg;
        seen_next  = 1'b0;
        cand_next  = cand_reg;
      end
      if (cnt_clear) begin
        cnt_next = '0;
      end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        latch_reg <= 2'b00;
        seen_reg  <= 1'b0;
        cand_reg  <= 2'b00;
        cnt_reg   <= '0;
      end else begin
        latch_reg <= latch_next;
        seen_reg  <= seen_next;
        cand_reg  <= cand_next;
        cnt_reg   <= cnt_next;
      end
    end

    assign conf_hit[gi]             = frame_tick_in && (cnt_upd == CONFIRM_MAX);
    assign cand_upd_flat[gi*2 +: 2] = cand_upd;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
      cmd_reg   <= 2'b00;
      src_reg   <= SRC_NONE;
      cool_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
      cmd_reg   <= cmd_next;
      src_reg   <= src_next;
      cool_reg  <= cool_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    valid_next = valid_reg;
    cmd_next   = cmd_reg;
    src_next   = src_reg;
    cool_next  = cool_reg;
    case (state_reg)
      IDLE: begin
        if (any_rise) begin
          cmd_next   = btn_code;
          src_next   = SRC_BTN;
          valid_next = 1'b1;
          state_next = PEND;
        end else if (conf_hit[1]) begin
          cmd_next   = cand_upd_flat[3:2];
          src_next   = SRC_KEY;
          valid_next = 1'b1;
          state_next = PEND;
        end else if (conf_hit[0]) begin
          cmd_next   = cand_upd_flat[1:0];
          src_next   = SRC_GEST;
          valid_next = 1'b1;
          state_next = PEND;
        end
      end
      PEND: begin
        if (handshake) begin
          valid_next = 1'b0;
          src_next   = SRC_NONE;
          if (COOLDOWN_LOAD == 8'd0) begin
            state_next = IDLE;
          end else begin
            cool_next  = COOLDOWN_LOAD;
            state_next = COOLDOWN;
          end
        end
      end
      COOLDOWN: begin
        if (frame_tick_in) begin
          cool_next = cool_reg - 8'd1;
          if (cool_reg <= 8'd1) state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        src_next   = SRC_NONE;
      end
    endcase
  end

  assign cmd_valid_out = valid_reg;
  assign cmd_out       = cmd_reg;
  assign cmd_src_out   = src_reg;
  assign decide_out    = decide_reg;
  assign state_out     = state_reg;

endmodule
